// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: operation codes, FSM states
// and the default datapath width.
package shift_pkg;

  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] OP_LLS = 2'b00;
  localparam logic [1:0] OP_LRS = 2'b01;
  localparam logic [1:0] OP_ARS = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift1_step.sv
// Combinational single-bit shift step shared by all four shifter operations.
module shift1_step
  import shift_pkg::*;
#(
  parameter int DATA_W = shift_pkg::DEF_DATA_W
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // One bit position of the selected shift or rotate.
  always_comb begin
    dout = din;
    case (op)
      OP_LLS:  dout = {din[DATA_W-2:0], 1'b0};
      OP_LRS:  dout = {1'b0, din[DATA_W-1:1]};
      OP_ARS:  dout = {din[DATA_W-1], din[DATA_W-1:1]};
      OP_ROL:  dout = {din[DATA_W-2:0], din[DATA_W-1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: applies one single-bit step per clock until the
// captured shift amount is exhausted, then presents the result with done.
module iter_shifter
  import shift_pkg::*;
#(
  parameter int DATA_W  = shift_pkg::DEF_DATA_W,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [DATA_W-1:0]  num,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result
);

  localparam logic [SHAMT_W-1:0] CNT_ZERO = SHAMT_W'(0);
  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

  state_t              state;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   work;
  logic [DATA_W-1:0]   step;
  logic [SHAMT_W-1:0]  cnt;

  shift1_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .op  (op_q),
    .din (work),
    .dout(step)
  );

  assign busy = (state != IDLE);

  // Control FSM plus work/count/result registers; done and result are
  // loaded on the edge that enters DONE so both appear in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_LLS;
      work   <= '0;
      cnt    <= CNT_ZERO;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work <= num;
            cnt  <= shamt;
            op_q <= op;
            if (shamt == CNT_ZERO) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= num;
            end else begin
              state <= SHIFT;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work <= step;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= step;
          end else begin
            state <= SHIFT;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: stimulus pushes expected result and done
// cycle from an arithmetic reference model, a monitor pops on each done pulse.
module tb_iter_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] num;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          done_log[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          n_exp = 0;
  int          n_done = 0;
  logic [31:0] prev_res = 32'd0;

  iter_shifter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .num   (num),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] n, input int s);
    logic signed [31:0] sn;
    logic [63:0]        dbl;
    sn  = n;
    dbl = {n, n} << s;
    case (o)
      2'd0:    return n << s;
      2'd1:    return n >> s;
      2'd2:    return sn >>> s;
      default: return dbl[63:32];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] n, input logic [4:0] s);
    exp_t e;
    op    = o;
    num   = n;
    shamt = s;
    start = 1'b1;
    e.res = model(o, n, int'(s));
    e.cyc = cyc + int'(s) + 1;
    q.push_back(e);
    n_exp++;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    num   = $urandom;
    shamt = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy still %b after 100 cycles, required 0", busy);
    end
  endtask

  // Monitor: pop expectation on done, otherwise result must hold its value.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        n_done++;
        done_log.push_back(cyc);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
        end else begin
          e = q.pop_front();
          check("result", result, e.res);
          check("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check("result_stable", result, prev_res);
      end
    end
    prev_res = result;
  end

  initial begin
    int d;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    num   = 32'd0;
    shamt = 5'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // lls by 31: busy must be high in cycles 1..32 exactly
    issue(2'd0, 32'h0000_0001, 5'd31);
    for (int k = 1; k <= 33; k++) begin
      check("busy_window", 32'(busy), (k <= 32) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("lls31_value", model(2'd0, 32'h1, 31), 32'h8000_0000);
    wait_idle();

    issue(2'd2, 32'h8000_00F0, 5'd4);
    wait_idle();
    issue(2'd1, 32'h8000_00F0, 5'd4);
    wait_idle();
    issue(2'd3, 32'h8000_0001, 5'd0);
    wait_idle();
    issue(2'd3, 32'h8000_0001, 5'd1);
    wait_idle();

    // start during SHIFT is ignored
    issue(2'd1, 32'hFF00_0000, 5'd8);
    @(negedge clk);
    num   = 32'h1234_5678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // start during DONE is ignored
    issue(2'd0, 32'h0000_00F3, 5'd2);
    @(negedge clk);
    @(negedge clk);
    check("done_cycle_busy", 32'(busy), 32'd1);
    num   = 32'hDEAD_BEEF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("done_start_ignored", 32'(busy), 32'd0);

    // asynchronous reset in cycle 3 of a 10-step operation
    issue(2'd1, 32'hA5A5_A5A5, 5'd10);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    q.delete();
    n_exp--;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    issue(2'd2, 32'h9000_0000, 5'd3);
    wait_idle();

    // back-to-back: second start in the IDLE cycle right after done
    issue(2'd0, 32'h0000_0F0F, 5'd5);
    wait_idle();
    issue(2'd3, 32'hC000_0003, 5'd7);
    wait_idle();
    d = done_log[done_log.size()-1] - done_log[done_log.size()-2];
    check("b2b_spacing", 32'(d), 32'd9);

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
